// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_FILL = 2'b01,
        S_RUN  = 2'b10
    } state_t;

    function automatic int len_w(input int max);
        return $clog2(max + 1);
    endfunction

endpackage

// File: rtl/seq_det_hist.sv
// History shift register plus saturating count of bits received since the last clear.
module seq_det_hist #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               shift,
    input  logic               clr_hist,
    input  logic               clr_fill,
    input  logic               bit_in,
    output logic [MAX_LEN-1:0] hist,
    output logic [LEN_W-1:0]   fill
);

    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist <= '0;
        end else if (clr_hist) begin
            hist <= '0;
        end else if (shift) begin
            hist <= {hist[MAX_LEN-2:0], bit_in};
        end
    end

    // A clear on the same cycle as a shift wins, so a non-overlap match restarts the window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill <= '0;
        end else if (clr_fill) begin
            fill <= '0;
        end else if (shift && (fill != FILL_MAX)) begin
            fill <= fill + 1'b1;
        end
    end

endmodule

// File: rtl/seq_det_prog.sv
// Runtime-programmable serial pattern detector with registered match pulse.
// Optional saturating match counter enabled by defining SEQ_DET_MATCH_CNT_EN.
module seq_det_prog
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               xin,
    input  logic               xin_vld,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pat,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_ovl,
    output logic               y,
    output logic               cfg_err,
    output logic               armed,
    output logic [CNT_W-1:0]   match_cnt
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    state_t               state_q, state_d;
    logic [MAX_LEN-1:0]   pat_q;
    logic [LEN_W-1:0]     len_q;
    logic                 ovl_q;
    logic [MAX_LEN-1:0]   hist;
    logic [LEN_W-1:0]     fill;
    logic                 shift, clr_hist, clr_fill, cfg_ok, match;
    logic [MAX_LEN-1:0]   new_hist, mask;
    logic [LEN_W-1:0]     new_fill;
    logic                 hist_msb_unused;

    seq_det_hist #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_hist (
        .clk      (clk),
        .reset    (reset),
        .shift    (shift),
        .clr_hist (clr_hist),
        .clr_fill (clr_fill),
        .bit_in   (xin),
        .hist     (hist),
        .fill     (fill)
    );

    assign hist_msb_unused = hist[MAX_LEN-1];

    assign cfg_ok   = cfg_load && (cfg_len != '0) && (cfg_len <= MAX_LEN_L);
    assign shift    = xin_vld && !cfg_load && (state_q != S_IDLE);
    assign new_hist = {hist[MAX_LEN-2:0], xin};
    assign new_fill = (fill == MAX_LEN_L) ? fill : fill + 1'b1;
    assign armed    = (state_q != S_IDLE);

    // Compare against the post-shift view; the fill gate keeps stale history from matching.
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_q));
        end
    end

    assign match = shift && (((new_hist ^ pat_q) & mask) == '0) && (new_fill >= len_q);

    always_comb begin
        state_d  = state_q;
        clr_hist = 1'b0;
        clr_fill = 1'b0;
        if (cfg_load) begin
            if (cfg_ok) begin
                state_d  = S_FILL;
                clr_hist = 1'b1;
                clr_fill = 1'b1;
            end
        end else if (shift) begin
            if (match && !ovl_q) begin
                state_d  = S_FILL;
                clr_fill = 1'b1;
            end else if (new_fill >= len_q) begin
                state_d  = S_RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            y       <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            state_q <= state_d;
            y       <= match;
            cfg_err <= cfg_load && !cfg_ok;
            if (cfg_ok) begin
                pat_q <= cfg_pat;
                len_q <= cfg_len;
                ovl_q <= cfg_ovl;
            end
        end
    end

`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Counts in step with the y pulse it accompanies.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (cfg_ok) begin
            cnt_q <= '0;
        end else if (match && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign match_cnt = cnt_q;
`else
    assign match_cnt = '0;
`endif

endmodule
